fp_mult_param: RTL and testbench
================================

// Module: fp_mult_param
// PURPOSE
//  Parametrised IEEE-754-style floating-point multiplier, next generation of the 32-bit FP multiplier.
//  Generic exponent/mantissa width; iterative shift-add mantissa multiply (one bit per clock).
//  Round-to-nearest-even, full special-value handling, valid/ready on both sides.
//  Sits between the operand-fetch FIFO and the result writeback stage of the FP datapath.
// PARAMETERS
//  EXP_W  8   exponent field width (bias = 2^(EXP_W-1)-1)
//  MAN_W  23  stored fraction width (significand = MAN_W+1 bits incl. hidden 1)
//  (W = 1+EXP_W+MAN_W, used below)
// PORTS
//  clk        in   1   rising-edge clock
//  rst_n      in   1   asynchronous reset, active low
//  in_valid   in   1   operands a/b valid
//  in_ready   out  1   block can accept operands (high only in IDLE)
//  a          in   W   operand A {sign, exp, frac}
//  b          in   W   operand B
//  out_valid  out  1   result p valid; held until out_ready
//  out_ready  in   1   downstream accepts p
//  p          out  W   product
//  flags      out  4   {invalid, overflow, underflow, inexact}; only with FP_FLAGS_EN
// BEHAVIOUR
//  Reset (rst_n low, any state): state=IDLE, in_ready=1, out_valid=0, p=0, flags=0; an in-flight op is discarded.
//  FSM: IDLE -> UNPACK -> {DONE | MULT} -> NORM -> ROUND -> DONE -> IDLE.
//   IDLE:   in_ready=1; on in_valid, register a/b, go UNPACK. a/b ignored in any other state.
//   UNPACK: classify; sign = sa^sb for every result, including zero, inf and overflow.
//    Subnormal input (exp=0): treated as zero (DAZ).
//    NaN in, or inf*zero: p = canonical qNaN {0, all-1s exp, 1'b1, zeros}; invalid=1; go DONE.
//    inf*(inf|normal): p = {sign, all-1s, 0}; go DONE.
//    zero*(zero|normal): p = {sign, 0, 0}; go DONE.
//    Otherwise: e = ea+eb-bias in EXP_W+2-bit signed arithmetic; clear 2*(MAN_W+1)-bit accumulator; go MULT.
//   MULT:   MAN_W+1 cycles, 1 multiplier bit per cycle (LSB first); cycle counter 0..MAN_W, exits at MAN_W.
//   NORM:   if product MSB set: e=e+1, take upper MAN_W+1 bits; else take the next MAN_W+1 bits.
//           Guard = next bit; sticky = OR of all lower bits.
//   ROUND:  RNE: increment if guard & (sticky | lsb). Carry-out of frac: frac=0, e=e+1.
//           e >= 2^EXP_W-1: p = {sign, all-1s, 0}; overflow=1; inexact=1.
//           e <= 0: p = {sign, 0, 0} (FTZ); underflow=1; inexact=1.
//           else pack {sign, e[EXP_W-1:0], frac}; inexact = guard|sticky.
//   DONE:   out_valid=1, p/flags stable; on out_ready go IDLE (out_valid drops next cycle).
//  Latency from accept edge to out_valid: special case 2 cycles; normal case MAN_W+5 cycles.
//  One op in flight; in_ready=0 from accept until return to IDLE.
//  No same-cycle DONE->accept: next op can be accepted at the earliest 1 cycle after the out handshake.
//  out_ready held low: DONE persists indefinitely; p unchanged.
// CONFIGURATION
//  FP_FLAGS_EN defined: flags port present, registered, updated at DONE entry, cleared on entering UNPACK.
//  FP_FLAGS_EN undefined: flags port absent, no flag logic; p identical in both builds.
// TESTING (EXP_W=8, MAN_W=23 unless noted)
//  a=0x40400000 (3.0), b=0x40200000 (2.5) -> p=0x40F00000 (7.5), flags=0000, out_valid 28 clocks after accept.
//  a=0x3F800001, b=0x3F800001 -> p=0x3F800002, inexact=1.
//  a=0x7F800000 (inf), b=0x80000000 (-0) -> p=0x7FC00000, invalid=1, 2-cycle latency.
//  a=0x7F7FFFFF, b=0x40000000 -> p=0x7F800000, overflow=1.
//  a=0x00800000, b=0x00800000 -> p=0x00000000, underflow=1.
//  a=0xBF800000, b=0x00000000 -> p=0x80000000.
//  Hold out_ready=0 for 10 cycles: p stable, in_ready=0.
//  Pulse rst_n low during MULT: out_valid=0, in_ready=1 immediately; the next op returns the correct result.
//  EXP_W=5, MAN_W=10: a=0x3C00, b=0xC000 -> p=0xC000 after 15 cycles.

Source files
------------

// File: rtl/fp_mult_param.sv
// fp_mult_param: parametrised floating-point multiplier with an iterative
// shift-add significand multiply (one multiplier bit per clock),
// round-to-nearest-even, DAZ on inputs and FTZ on results.
//
// Parameters: EXP_W (exponent width, bias 2^(EXP_W-1)-1), MAN_W (fraction width).
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready   operand handshake; in_ready is high only while idle
//   a, b                operands {sign, exp, frac}
//   out_valid/out_ready result handshake; p is held until accepted
//   p                   product
//   flags               {invalid, overflow, underflow, inexact}; present only
//                       when FP_FLAGS_EN is defined
module fp_mult_param #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  output logic                   out_valid,
  input  logic                   out_ready,
`ifdef FP_FLAGS_EN
  output logic [3:0]             flags,
`endif
  output logic [EXP_W+MAN_W:0]   p
);

  localparam int W     = 1 + EXP_W + MAN_W;
  localparam int S     = MAN_W + 1;
  localparam int CNT_W = $clog2(S);
  localparam logic signed [EXP_W+1:0] BIAS   = (EXP_W+2)'((1 << (EXP_W-1)) - 1);
  localparam logic signed [EXP_W+1:0] MAX_E  = (EXP_W+2)'((1 << EXP_W) - 1);
  localparam logic signed [EXP_W+1:0] ZERO_E = '0;
  localparam logic signed [EXP_W+1:0] ONE_E  = (EXP_W+2)'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_UNPACK, S_MULT, S_NORM, S_ROUND, S_DONE
  } state_t;

  state_t                   state_q, state_d;
  logic [W-1:0]             a_q, a_d, b_q, b_d;
  logic                     sign_q, sign_d;
  logic signed [EXP_W+1:0]  exp_q, exp_d;
  logic [2*S-1:0]           mcand_q, mcand_d;
  logic [S-1:0]             mplier_q, mplier_d;
  logic [2*S-1:0]           acc_q, acc_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [MAN_W-1:0]         frac_q, frac_d;
  logic                     guard_q, guard_d, sticky_q, sticky_d;
  logic [W-1:0]             p_q, p_d;
  logic                     in_ready_q, in_ready_d, out_valid_q, out_valid_d;
`ifdef FP_FLAGS_EN
  logic [3:0]               flags_q, flags_d;
`endif

  // Operand classification (subnormals read as zero)
  logic [EXP_W-1:0] exp_a, exp_b;
  logic             a_max, b_max, a_zero, b_zero, a_nan, b_nan, a_inf, b_inf;
  logic             sign_ab;

  // Rounding datapath
  logic                     round_inc;
  logic [MAN_W:0]           frac_sum;
  logic signed [EXP_W+1:0]  exp_rnd;

  always_comb begin
    exp_a   = a_q[W-2:MAN_W];
    exp_b   = b_q[W-2:MAN_W];
    a_max   = &exp_a;
    b_max   = &exp_b;
    a_zero  = ~|exp_a;
    b_zero  = ~|exp_b;
    a_nan   = a_max & (|a_q[MAN_W-1:0]);
    b_nan   = b_max & (|b_q[MAN_W-1:0]);
    a_inf   = a_max & ~(|a_q[MAN_W-1:0]);
    b_inf   = b_max & ~(|b_q[MAN_W-1:0]);
    sign_ab = a_q[W-1] ^ b_q[W-1];

    round_inc = guard_q & (sticky_q | frac_q[0]);
    frac_sum  = {1'b0, frac_q} + {{MAN_W{1'b0}}, round_inc};
    // A carry out of the fraction leaves frac_sum[MAN_W-1:0] at zero already
    exp_rnd   = exp_q + (frac_sum[MAN_W] ? ONE_E : ZERO_E);
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    sign_d   = sign_q;
    exp_d    = exp_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    frac_d   = frac_q;
    guard_d  = guard_q;
    sticky_d = sticky_q;
    p_d      = p_q;
`ifdef FP_FLAGS_EN
    flags_d  = flags_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
`ifdef FP_FLAGS_EN
          flags_d = '0;
`endif
          state_d = S_UNPACK;
        end
      end

      S_UNPACK: begin
        sign_d = sign_ab;
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
          p_d     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
`ifdef FP_FLAGS_EN
          flags_d = 4'b1000;
`endif
          state_d = S_DONE;
        end else if (a_inf || b_inf) begin
          p_d     = {sign_ab, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          state_d = S_DONE;
        end else if (a_zero || b_zero) begin
          p_d     = {sign_ab, {(W-1){1'b0}}};
          state_d = S_DONE;
        end else begin
          exp_d    = $signed({2'b00, exp_a}) + $signed({2'b00, exp_b}) - BIAS;
          mcand_d  = {{S{1'b0}}, 1'b1, a_q[MAN_W-1:0]};
          mplier_d = {1'b1, b_q[MAN_W-1:0]};
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = S_MULT;
        end
      end

      S_MULT: begin
        // Multiplier consumed LSB first against a left-shifting multiplicand
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(MAN_W)) state_d = S_NORM;
      end

      S_NORM: begin
        if (acc_q[2*S-1]) begin
          exp_d    = exp_q + ONE_E;
          frac_d   = acc_q[2*S-2:S];
          guard_d  = acc_q[S-1];
          sticky_d = |acc_q[S-2:0];
        end else begin
          frac_d   = acc_q[2*S-3:S-1];
          guard_d  = acc_q[S-2];
          sticky_d = |acc_q[S-3:0];
        end
        state_d = S_ROUND;
      end

      S_ROUND: begin
        if (exp_rnd >= MAX_E) begin
          p_d     = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
`ifdef FP_FLAGS_EN
          flags_d = 4'b0101;
`endif
        end else if (exp_rnd <= ZERO_E) begin
          p_d     = {sign_q, {(W-1){1'b0}}};
`ifdef FP_FLAGS_EN
          flags_d = 4'b0011;
`endif
        end else begin
          p_d     = {sign_q, exp_rnd[EXP_W-1:0], frac_sum[MAN_W-1:0]};
`ifdef FP_FLAGS_EN
          flags_d = {3'b000, guard_q | sticky_q};
`endif
        end
        state_d = S_DONE;
      end

      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sign_q      <= 1'b0;
      exp_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      frac_q      <= '0;
      guard_q     <= 1'b0;
      sticky_q    <= 1'b0;
      p_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef FP_FLAGS_EN
      flags_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sign_q      <= sign_d;
      exp_q       <= exp_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      frac_q      <= frac_d;
      guard_q     <= guard_d;
      sticky_q    <= sticky_d;
      p_q         <= p_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
`ifdef FP_FLAGS_EN
      flags_q     <= flags_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign p         = p_q;
`ifdef FP_FLAGS_EN
  assign flags     = flags_q;
`endif

endmodule

// File: tb/tb_fp_mult_param.sv
// tb_fp_mult_param: directed bench for fp_mult_param, single precision
// (EXP_W=8, MAN_W=23) plus a half-precision instance (EXP_W=5, MAN_W=10).
// Expected results are queued when operands are driven and compared when
// out_valid rises. Latency counts the accept edge as clock 1.
module tb_fp_mult_param;

  typedef struct {
    logic [31:0] p;
    logic [3:0]  fl;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b, p;
  logic [3:0]  flags;

  logic        h_in_valid, h_in_ready, h_out_valid, h_out_ready;
  logic [15:0] h_a, h_b, h_p;
  logic [3:0]  h_flags;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  fp_mult_param #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
`ifdef FP_FLAGS_EN
    .flags(flags),
`endif
    .p(p)
  );

  fp_mult_param #(.EXP_W(5), .MAN_W(10)) dut_h (
    .clk(clk), .rst_n(rst_n), .in_valid(h_in_valid), .in_ready(h_in_ready),
    .a(h_a), .b(h_b), .out_valid(h_out_valid), .out_ready(h_out_ready),
`ifdef FP_FLAGS_EN
    .flags(h_flags),
`endif
    .p(h_p)
  );

`ifndef FP_FLAGS_EN
  assign flags   = 4'b0000;
  assign h_flags = 4'b0000;
`endif

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask

  // Called at #1 after a rising edge; returns at #1 after the out handshake edge
  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v,
                        input logic [31:0] ep, input logic [3:0] ef,
                        input int elat, input int hold, input string tag);
    exp_t e;
    int   lat;
    chk({tag, " in_ready idle"}, {31'd0, in_ready}, 32'd1);
    a        = ta;
    b        = tb_v;
    in_valid = 1'b1;
    sb.push_back('{p: ep, fl: ef, lat: elat});
    @(posedge clk); #1;
    in_valid = 1'b0;
    a        = '1;
    b        = '1;
    chk({tag, " in_ready busy"}, {31'd0, in_ready}, 32'd0);
    lat = 1;
    while (out_valid !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " latency"}, lat, elat);
    if (sb.size() == 0) begin
      chk({tag, " scoreboard empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, " p"}, p, e.p);
`ifdef FP_FLAGS_EN
      chk({tag, " flags"}, {28'd0, flags}, {28'd0, e.fl});
`endif
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, " hold p"}, p, ep);
      chk({tag, " hold in_ready"}, {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, " out_valid drop"}, {31'd0, out_valid}, 32'd0);
  endtask

  task automatic run_h(input logic [15:0] ta, input logic [15:0] tb_v,
                       input logic [15:0] ep, input int elat, input string tag);
    int lat;
    h_a        = ta;
    h_b        = tb_v;
    h_in_valid = 1'b1;
    @(posedge clk); #1;
    h_in_valid = 1'b0;
    lat = 1;
    while (h_out_valid !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " latency"}, lat, elat);
    chk({tag, " p"}, {16'd0, h_p}, {16'd0, ep});
    h_out_ready = 1'b1;
    @(posedge clk); #1;
    h_out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    h_in_valid = 1'b0; h_out_ready = 1'b0; h_a = '0; h_b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset p", p, 32'd0);
`ifdef FP_FLAGS_EN
    chk("reset flags", {28'd0, flags}, 32'd0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(32'h40400000, 32'h40200000, 32'h40F00000, 4'b0000, 28, 0, "3x2.5");
    run_op(32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001, 28, 0, "rne sticky");
    run_op(32'h7F800000, 32'h80000000, 32'h7FC00000, 4'b1000,  2, 0, "inf x -0");
    run_op(32'h7F7FFFFF, 32'h40000000, 32'h7F800000, 4'b0101, 28, 0, "overflow");
    run_op(32'h00800000, 32'h00800000, 32'h00000000, 4'b0011, 28, 0, "underflow");
    run_op(32'hBF800000, 32'h00000000, 32'h80000000, 4'b0000,  2, 0, "-1 x 0");
    run_op(32'hC0400000, 32'h40200000, 32'hC0F00000, 4'b0000, 28, 0, "-3x2.5");
    run_op(32'h3FC00000, 32'h3FC00000, 32'h40100000, 4'b0000, 28, 0, "msb norm");
    run_op(32'h3F800001, 32'h3FC00000, 32'h3FC00002, 4'b0001, 28, 0, "rne tie odd");
    run_op(32'h3FFFFFFF, 32'h3F800001, 32'h40000000, 4'b0001, 28, 0, "round carry");
    run_op(32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000,  2, 0, "-inf x 2");
    run_op(32'h7FC12345, 32'h3F800000, 32'h7FC00000, 4'b1000,  2, 0, "nan in");
    run_op(32'h00000001, 32'h3F800000, 32'h00000000, 4'b0000,  2, 0, "daz");
    run_op(32'h40400000, 32'h40200000, 32'h40F00000, 4'b0000, 28, 10, "hold");

    // Reset pulse while the multiply loop is running
    a = 32'h40400000; b = 32'h40200000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid reset out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid reset in_ready", {31'd0, in_ready}, 32'd1);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(32'h3FC00000, 32'h40200000, 32'h40700000, 4'b0000, 28, 0, "after reset");

    run_h(16'h3C00, 16'hC000, 16'hC000, 15, "half 1x-2");
    run_h(16'h3E00, 16'h4100, 16'h4380, 15, "half 1.5x2.5");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
